// File: rtl/csr_pkg.sv
// Shared definitions for the ChaCha20 Avalon-MM CSR bank.
//
// Contents:
//   CTRL_OFS, STAT_OFS, DATA_BASE  word offsets in the register map
//   START, IRQ_EN                  CTRL bit positions
//   BUSY, DONE, ERR                STATUS bit positions
//   be_merge()                     byte-lane merge of a write into an existing word
//
// be_merge works on a wide fixed-size container so that any DATA_W up to
// MERGE_W can use it. Callers zero-extend their operands into the container
// and truncate the result back to their own width.
package csr_pkg;

  localparam int CTRL_OFS  = 0;
  localparam int STAT_OFS  = 1;
  localparam int DATA_BASE = 2;

  localparam int START  = 0;
  localparam int IRQ_EN = 1;

  localparam int BUSY = 0;
  localparam int DONE = 1;
  localparam int ERR  = 2;

  localparam int MERGE_W  = 1024;
  localparam int MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]  old_val,
    input logic [MERGE_W-1:0]  new_val,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] merged;
    merged = old_val;
    for (int b = 0; b < MERGE_BE; b++) begin
      if (be[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/csr_word_reg.sv
// One byte-enabled data word of the CSR bank.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset, clears the word
//   we       in   write enable for this word
//   be       in   DATA_W/8 byte lane enables; only enabled lanes are updated
//   wdata    in   DATA_W write data
//   q        out  DATA_W stored word
module csr_word_reg
  import csr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (we) begin
      q <= DATA_W'(be_merge(MERGE_W'(q), MERGE_W'(wdata), MERGE_BE'(be)));
    end
  end

endmodule

// File: rtl/avalon_csr_bank.sv
// Avalon-MM slave register bank feeding the ChaCha20 core.
//
// Map: 0 = CTRL (START pulse, IRQ_EN), 1 = STATUS (BUSY, DONE W1C, ERR W1C),
//      2..NUM_DATA+1 = key/nonce/counter data words.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   address, chipselect           word address and slave select
//   read, write                   access requests (write wins if both)
//   byteenable, writedata         write lanes and data
//   readdata, readdatavalid       read response, one cycle after acceptance
//   irq                           registered DONE & IRQ_EN
//   core_start                    one-cycle start pulse to the core
//   core_busy, core_done          core status inputs
//   data_out                      all data words, word k at [k*DATA_W +: DATA_W]
module avalon_csr_bank
  import csr_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 16,
  parameter int ADDR_W   = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          address,
  input  logic                       chipselect,
  input  logic                       read,
  input  logic                       write,
  input  logic [DATA_W/8-1:0]        byteenable,
  input  logic [DATA_W-1:0]          writedata,
  output logic [DATA_W-1:0]          readdata,
  output logic                       readdatavalid,
  output logic                       irq,
  output logic                       core_start,
  input  logic                       core_busy,
  input  logic                       core_done,
  output logic [NUM_DATA*DATA_W-1:0] data_out
);

  logic                wr_acc;
  logic                rd_acc;
  logic                hit_ctrl;
  logic                hit_stat;
  logic [NUM_DATA-1:0] hit_data;
  logic [DATA_W-1:0]   word_q [NUM_DATA];
  logic [DATA_W-1:0]   rd_mux;

  logic irq_en_q;
  logic done_q;
  logic err_q;

  logic start_req;
  logic err_set;
  logic done_clr;
  logic err_clr;

  // A simultaneous read+write is treated as a write only, so the read is
  // suppressed here rather than at the response register.
  assign wr_acc = chipselect & write;
  assign rd_acc = chipselect & read & ~write;

  assign hit_ctrl = (address == ADDR_W'(CTRL_OFS));
  assign hit_stat = (address == ADDR_W'(STAT_OFS));

  always_comb begin
    hit_data = '0;
    for (int k = 0; k < NUM_DATA; k++) begin
      hit_data[k] = (address == ADDR_W'(DATA_BASE + k));
    end
  end

  // The data words are frozen while the core is running so it never sees a
  // key or nonce change mid-block.
  for (genvar k = 0; k < NUM_DATA; k++) begin : g_word
    csr_word_reg #(.DATA_W(DATA_W)) u_word (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_acc & hit_data[k] & ~core_busy),
      .be      (byteenable),
      .wdata   (writedata),
      .q       (word_q[k])
    );
    assign data_out[k*DATA_W +: DATA_W] = word_q[k];
  end

  // All CTRL/STATUS bits live in byte lane 0, so lane 0 gates every
  // control-word update.
  assign start_req = wr_acc & hit_ctrl & byteenable[0] & writedata[START];
  assign err_set   = (wr_acc & (|hit_data) & core_busy) | (start_req & core_busy);
  assign done_clr  = wr_acc & hit_stat & byteenable[0] & writedata[DONE];
  assign err_clr   = wr_acc & hit_stat & byteenable[0] & writedata[ERR];

  // Control and sticky status flags; a set in the same cycle as a W1C wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_start <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_acc & hit_ctrl & byteenable[0]) irq_en_q <= writedata[IRQ_EN];
      done_q     <= core_done | (done_q & ~done_clr);
      err_q      <= err_set | (err_q & ~err_clr);
      core_start <= start_req & ~core_busy;
      irq        <= done_q & irq_en_q;
    end
  end

  // Read mux samples the pre-update register values; out-of-range reads fall
  // through to zero.
  always_comb begin
    rd_mux = '0;
    if (hit_ctrl) begin
      rd_mux[IRQ_EN] = irq_en_q;
    end else if (hit_stat) begin
      rd_mux[BUSY] = core_busy;
      rd_mux[DONE] = done_q;
      rd_mux[ERR]  = err_q;
    end else begin
      for (int k = 0; k < NUM_DATA; k++) begin
        if (hit_data[k]) rd_mux = word_q[k];
      end
    end
  end

  // Response register: readdata is forced to zero outside the valid cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_acc;
      readdata      <= rd_acc ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_avalon_csr_bank.sv
// Self-checking bench for avalon_csr_bank.
// Reads push their expected data into a queue; a monitor on the falling edge
// pops and compares whenever readdatavalid is high. Side-band outputs
// (data_out, core_start, irq) are checked directly by the stimulus process.
module tb_avalon_csr_bank;

  localparam int DATA_W   = 32;
  localparam int NUM_DATA = 16;
  localparam int ADDR_W   = 5;
  localparam int BE_W     = DATA_W / 8;

  logic                       clk;
  logic                       reset_n;
  logic [ADDR_W-1:0]          address;
  logic                       chipselect;
  logic                       read;
  logic                       write;
  logic [BE_W-1:0]            byteenable;
  logic [DATA_W-1:0]          writedata;
  logic [DATA_W-1:0]          readdata;
  logic                       readdatavalid;
  logic                       irq;
  logic                       core_start;
  logic                       core_busy;
  logic                       core_done;
  logic [NUM_DATA*DATA_W-1:0] data_out;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q [$];

  avalon_csr_bank #(
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .irq           (irq),
    .core_start    (core_start),
    .core_busy     (core_busy),
    .core_done     (core_done),
    .data_out      (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rdv: got readdatavalid=1 with readdata 0x%08h, expected no response",
                 readdata);
      end else begin
        check_output("readdata", readdata, exp_q.pop_front());
      end
    end
  end

  // Inputs change 1ns after a rising edge and are sampled on the next one.
  task automatic bus_write(input int addr, input logic [31:0] data, input logic [3:0] be);
    address    = ADDR_W'(addr);
    writedata  = data;
    byteenable = be;
    chipselect = 1'b1;
    write      = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input int addr, input logic [31:0] expected);
    exp_q.push_back(expected);
    address    = ADDR_W'(addr);
    chipselect = 1'b1;
    read       = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = '0;
    writedata  = '0;
    core_busy  = 1'b0;
    core_done  = 1'b0;

    // 1: reset state, then every address reads 0
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_rdv", 32'(readdatavalid), 32'h0);
    check_output("rst_irq", 32'(irq), 32'h0);
    check_output("rst_start", 32'(core_start), 32'h0);
    check_output("rst_word0", data_out[0 +: 32], 32'h0);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) bus_read(a, 32'h0);
    tick();
    check_output("irq_idle", 32'(irq), 32'h0);

    // 2: full write then partial byte-enabled write
    bus_write(2, 32'hA5A5_A5A5, 4'b1111);
    check_output("data_out_w0_full", data_out[0 +: 32], 32'hA5A5_A5A5);
    bus_write(2, 32'h0000_1111, 4'b0011);
    check_output("data_out_w0_part", data_out[0 +: 32], 32'hA5A5_1111);
    bus_read(2, 32'hA5A5_1111);
    bus_write(17, 32'h1357_9BDF, 4'b1111);
    check_output("data_out_w15", data_out[15*32 +: 32], 32'h1357_9BDF);
    bus_read(17, 32'h1357_9BDF);
    bus_write(20, 32'hFFFF_FFFF, 4'b1111);
    bus_read(20, 32'h0);
    bus_write(2, 32'hFF00_FF00, 4'b0000);
    bus_read(2, 32'hA5A5_1111);

    // 3: START pulse, then START while busy
    bus_write(0, 32'h3, 4'b1111);
    check_output("start_pulse", 32'(core_start), 32'h1);
    tick();
    check_output("start_one_cycle", 32'(core_start), 32'h0);
    bus_read(0, 32'h2);
    core_busy = 1'b1;
    bus_write(0, 32'h3, 4'b1111);
    check_output("start_busy", 32'(core_start), 32'h0);
    tick();
    check_output("start_busy_late", 32'(core_start), 32'h0);
    bus_read(1, 32'h5);
    core_busy = 1'b0;
    bus_write(1, 32'h4, 4'b1111);
    bus_read(1, 32'h0);

    // 4: DONE / irq behaviour, W1C and set-vs-clear collision
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    check_output("irq_set", 32'(irq), 32'h1);
    bus_read(1, 32'h2);
    bus_write(1, 32'h2, 4'b1111);
    tick();
    check_output("irq_clear", 32'(irq), 32'h0);
    bus_read(1, 32'h0);
    core_done  = 1'b1;
    address    = ADDR_W'(1);
    writedata  = 32'h2;
    byteenable = 4'b1111;
    chipselect = 1'b1;
    write      = 1'b1;
    tick();
    core_done  = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    bus_read(1, 32'h2);
    bus_write(1, 32'h2, 4'b1111);
    bus_read(1, 32'h0);

    // 5: data write while busy, ERR clear, read+write collision
    core_busy = 1'b1;
    bus_write(3, 32'h1234_5678, 4'b1111);
    check_output("data_out_w1_busy", data_out[32 +: 32], 32'h0);
    core_busy = 1'b0;
    bus_read(3, 32'h0);
    bus_read(1, 32'h4);
    bus_write(1, 32'h4, 4'b1111);
    bus_read(1, 32'h0);
    address    = ADDR_W'(3);
    writedata  = 32'hCAFE_F00D;
    byteenable = 4'b1111;
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b1;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    check_output("rw_no_rdv", 32'(readdatavalid), 32'h0);
    check_output("data_out_w1_rw", data_out[32 +: 32], 32'hCAFE_F00D);
    bus_read(3, 32'hCAFE_F00D);

    // 6: reset in the middle of back-to-back reads
    bus_read(2, 32'hA5A5_1111);
    bus_read(3, 32'hCAFE_F00D);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("rst_mid_rdv", 32'(readdatavalid), 32'h0);
    check_output("rst_mid_rdata", readdata, 32'h0);
    check_output("rst_mid_word0", data_out[0 +: 32], 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    bus_read(0, 32'h0);
    bus_read(1, 32'h0);
    bus_read(2, 32'h0);
    bus_read(3, 32'h0);
    bus_read(17, 32'h0);
    check_output("post_rst_word1", data_out[32 +: 32], 32'h0);
    check_output("post_rst_word15", data_out[15*32 +: 32], 32'h0);
    check_output("post_rst_irq", 32'(irq), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check_output("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
